// File: rtl/cpu6502_dma_arbiter.sv
// Cpu6502 bus arbiter with a page-copy DMA engine (OAM-style sprite DMA).
// Define CPU6502_DMA_ALIGN_EN to make the first DMA read wait for a GET bus cycle.
module cpu6502_dma_arbiter #(
  parameter logic [15:0] TRIGGER_ADDR = 16'h4014,
  parameter logic [15:0] DEST_ADDR    = 16'h2004,
  parameter int unsigned LENGTH       = 256
) (
  input  logic        clock,
  input  logic        nReset,
  input  logic        tick,
  input  logic [15:0] cpuAddress,
  input  logic [7:0]  cpuDataOut,
  input  logic        cpuWriteEnable,
  output logic        cpuEnable,
  output logic [15:0] busAddress,
  output logic [7:0]  busDataOut,
  output logic        busWriteEnable,
  input  logic [7:0]  busDataIn,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_ALIGN = 3'd2,
    S_READ  = 3'd3,
    S_WRITE = 3'd4
  } state_t;

  localparam logic [7:0] LAST_INDEX = 8'(LENGTH - 1);

  state_t     state_q, state_d;
  logic [7:0] page_q, page_d;
  logic [7:0] index_q, index_d;
  logic [7:0] latch_q, latch_d;
  logic       parity_get_s;

`ifdef CPU6502_DMA_ALIGN_EN
  logic parity_q;

  // Bus-cycle parity: 0 = GET, 1 = PUT; flips on every CPU cycle.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      parity_q <= 1'b0;
    end else if (tick) begin
      parity_q <= ~parity_q;
    end
  end

  assign parity_get_s = (parity_q == 1'b0);
`else
  assign parity_get_s = 1'b1;
`endif

  // State and datapath registers.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      state_q <= S_IDLE;
      page_q  <= 8'h00;
      index_q <= 8'h00;
      latch_q <= 8'h00;
    end else begin
      state_q <= state_d;
      page_q  <= page_d;
      index_q <= index_d;
      latch_q <= latch_d;
    end
  end

  // Next-state logic, advanced only on CPU cycle strobes.
  always_comb begin
    state_d = state_q;
    page_d  = page_q;
    index_d = index_q;
    latch_d = latch_q;
    if (tick) begin
      case (state_q)
        S_IDLE: begin
          if (cpuWriteEnable && (cpuAddress == TRIGGER_ADDR)) begin
            page_d  = cpuDataOut;
            index_d = 8'h00;
            state_d = S_WAIT;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_WAIT: begin
          // The CPU is never halted on a write; the first read becomes the halt cycle.
          if (!cpuWriteEnable) begin
            state_d = S_ALIGN;
          end else begin
            state_d = S_WAIT;
          end
        end
        S_ALIGN: begin
          if (parity_get_s) begin
            latch_d = busDataIn;
            state_d = S_WRITE;
          end else begin
            state_d = S_ALIGN;
          end
        end
        S_READ: begin
          latch_d = busDataIn;
          state_d = S_WRITE;
        end
        S_WRITE: begin
          if (index_q == LAST_INDEX) begin
            index_d = 8'h00;
            state_d = S_IDLE;
          end else begin
            index_d = index_q + 8'h01;
            state_d = S_READ;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Bus mux: the CPU owns the bus except while the DMA is copying.
  always_comb begin
    cpuEnable      = 1'b0;
    busAddress     = cpuAddress;
    busDataOut     = cpuDataOut;
    busWriteEnable = 1'b0;
    if (!nReset) begin
      cpuEnable      = 1'b0;
      busWriteEnable = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          cpuEnable      = tick;
          busWriteEnable = cpuWriteEnable;
        end
        S_WAIT: begin
          if (cpuWriteEnable) begin
            cpuEnable      = tick;
            busWriteEnable = 1'b1;
          end else begin
            cpuEnable      = 1'b0;
            busWriteEnable = 1'b0;
          end
        end
        S_ALIGN: begin
          // On a GET cycle the first source read happens right here.
          if (parity_get_s) begin
            busAddress = {page_q, index_q};
          end else begin
            busAddress = cpuAddress;
          end
        end
        S_READ: begin
          busAddress = {page_q, index_q};
        end
        S_WRITE: begin
          busAddress     = DEST_ADDR;
          busDataOut     = latch_q;
          busWriteEnable = 1'b1;
        end
        default: begin
          cpuEnable = 1'b0;
        end
      endcase
    end
  end

  assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_cpu6502_dma_arbiter.sv
// Scoreboard bench for cpu6502_dma_arbiter: stimulus pushes expected bus cycles,
// a negedge monitor pops and compares them on every CPU tick.
module tb_cpu6502_dma_arbiter;

  localparam logic [15:0] TRIG = 16'h4014;
  localparam logic [15:0] DEST = 16'h2004;
  localparam int          LEN  = 256;
`ifdef CPU6502_DMA_ALIGN_EN
  localparam int ALIGN_EN = 1;
`else
  localparam int ALIGN_EN = 0;
`endif

  logic        clock = 1'b0;
  logic        nReset, tick, cpuWriteEnable;
  logic [15:0] cpuAddress;
  logic [7:0]  cpuDataOut;
  logic        cpuEnable, busWriteEnable, busy;
  logic [15:0] busAddress;
  logic [7:0]  busDataOut, busDataIn;

  logic [7:0] mem [0:65535];

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
    logic        we;
    logic        en;
    logic        bsy;
    logic        cd;
  } item_t;

  item_t sb[$];
  int n_tests = 0;
  int n_fail  = 0;
  int tick_count = 0;
  int low_ticks  = 0;

  cpu6502_dma_arbiter dut (
    .clock          (clock),
    .nReset         (nReset),
    .tick           (tick),
    .cpuAddress     (cpuAddress),
    .cpuDataOut     (cpuDataOut),
    .cpuWriteEnable (cpuWriteEnable),
    .cpuEnable      (cpuEnable),
    .busAddress     (busAddress),
    .busDataOut     (busDataOut),
    .busWriteEnable (busWriteEnable),
    .busDataIn      (busDataIn),
    .busy           (busy)
  );

  always #5 clock = ~clock;
  assign busDataIn = mem[busAddress];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every tick cycle consumes one expected item; idle cycles must not move the bus.
  initial begin
    item_t       e;
    logic        gap_valid;
    logic [15:0] gap_addr;
    logic        gap_we;
    gap_valid = 1'b0;
    gap_addr  = 16'h0000;
    gap_we    = 1'b0;
    forever begin
      @(negedge clock);
      if (!nReset) begin
        gap_valid = 1'b0;
      end else if (tick) begin
        gap_valid = 1'b0;
        if (!cpuEnable) low_ticks++;
        if (sb.size() == 0) begin
          chk("unexpected_tick", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("busAddress", {16'h0, busAddress}, {16'h0, e.addr});
          chk("busWriteEnable", {31'h0, busWriteEnable}, {31'h0, e.we});
          chk("cpuEnable", {31'h0, cpuEnable}, {31'h0, e.en});
          chk("busy", {31'h0, busy}, {31'h0, e.bsy});
          if (e.cd) chk("busDataOut", {24'h0, busDataOut}, {24'h0, e.data});
        end
      end else begin
        chk("cpuEnable_notick", {31'h0, cpuEnable}, 32'd0);
        if (busy) begin
          if (gap_valid) begin
            chk("gap_addr", {16'h0, busAddress}, {16'h0, gap_addr});
            chk("gap_we", {31'h0, busWriteEnable}, {31'h0, gap_we});
          end else begin
            gap_addr  = busAddress;
            gap_we    = busWriteEnable;
            gap_valid = 1'b1;
          end
        end
      end
    end
  end

  task automatic drive(input logic [15:0] a, input logic [7:0] d, input logic w);
    cpuAddress     = a;
    cpuDataOut     = d;
    cpuWriteEnable = w;
    tick           = 1'b1;
    @(posedge clock);
    #1;
    tick_count++;
  endtask

  task automatic idle(input int n);
    tick = 1'b0;
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic cpu_cycle(input logic [15:0] a, input logic [7:0] d, input logic w, input logic bsy);
    item_t it;
    it = '{addr: a, data: d, we: w, en: 1'b1, bsy: bsy, cd: 1'b1};
    sb.push_back(it);
    drive(a, d, w);
  endtask

  task automatic rand_cycles(input int n);
    logic [15:0] a;
    for (int i = 0; i < n; i++) begin
      a = 16'($urandom);
      if (a == TRIG) a = a ^ 16'h0001;
      cpu_cycle(a, 8'($urandom), 1'($urandom), 1'b0);
    end
  endtask

  // Make the next tick index even (want=0) or odd (want=1).
  task automatic align_to(input int want);
    if ((tick_count % 2) != want) rand_cycles(1);
  endtask

  // Halt on a CPU read of raddr and run the copy; stop_after>0 truncates it.
  task automatic run_dma(input logic [7:0] page, input logic [15:0] raddr,
                         input int stop_after, input int gap_at, output int total);
    item_t q[$];
    item_t it;
    int    extra;
    int    n;
    logic [15:0] src;
    extra = (ALIGN_EN == 1 && (tick_count % 2) == 0) ? 1 : 0;
    it = '{addr: raddr, data: 8'h00, we: 1'b0, en: 1'b0, bsy: 1'b1, cd: 1'b0};
    q.push_back(it);
    if (extra == 1) q.push_back(it);
    for (int i = 0; i < LEN; i++) begin
      src = {page, 8'(i)};
      it = '{addr: src, data: 8'h00, we: 1'b0, en: 1'b0, bsy: 1'b1, cd: 1'b0};
      q.push_back(it);
      it = '{addr: DEST, data: mem[src], we: 1'b1, en: 1'b0, bsy: 1'b1, cd: 1'b1};
      q.push_back(it);
    end
    total = q.size();
    n = (stop_after > 0) ? stop_after : total;
    low_ticks = 0;
    for (int k = 0; k < n; k++) begin
      if (k == gap_at) idle(5);
      else if (k > 0 && $urandom_range(0, 31) == 0) idle(1);
      sb.push_back(q[k]);
      drive(raddr, 8'($urandom), 1'b0);
    end
  endtask

  initial begin
    int total;
    logic [15:0] ra;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);

    // Outputs while held in reset
    nReset = 1'b0;
    tick = 1'b1;
    cpuAddress = 16'h1234;
    cpuDataOut = 8'hA5;
    cpuWriteEnable = 1'b1;
    #3;
    chk("rst_cpuEnable", {31'h0, cpuEnable}, 32'd0);
    chk("rst_we", {31'h0, busWriteEnable}, 32'd0);
    chk("rst_busy", {31'h0, busy}, 32'd0);
    chk("rst_addr", {16'h0, busAddress}, 32'h1234);
    chk("rst_data", {24'h0, busDataOut}, 32'hA5);
    tick = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    nReset = 1'b1;
    tick_count = 0;
    rand_cycles(6);

    // Page 02, halt on a PUT cycle
    align_to(0);
    cpu_cycle(TRIG, 8'h02, 1'b1, 1'b0);
    ra = 16'hC123;
    run_dma(8'h02, ra, 0, -1, total);
    chk("t1_low_ticks", low_ticks, 32'd513);
    cpu_cycle(ra, 8'h00, 1'b0, 1'b0);
    rand_cycles(3);

    // Page 02, halt on a GET cycle
    align_to(1);
    cpu_cycle(TRIG, 8'h02, 1'b1, 1'b0);
    ra = 16'hC456;
    run_dma(8'h02, ra, 0, -1, total);
    chk("t2_low_ticks", low_ticks, (ALIGN_EN == 1) ? 32'd514 : 32'd513);
    cpu_cycle(ra, 8'h00, 1'b0, 1'b0);

    // RMW-style writes in WAIT (second hits the trigger, ignored), 5-clock tick gap at index 40
    cpu_cycle(TRIG, 8'h13, 1'b1, 1'b0);
    cpu_cycle(16'h0321, 8'h5A, 1'b1, 1'b1);
    cpu_cycle(TRIG, 8'h77, 1'b1, 1'b1);
    ra = 16'h8000 | 16'($urandom_range(1, 16'h7FFF));
    run_dma(8'h13, ra, 0, 1 + ((ALIGN_EN == 1 && (tick_count % 2) == 0) ? 1 : 0) + 2 * 8'h40, total);
    chk("t3_low_ticks", low_ticks, total);
    cpu_cycle(ra, 8'h00, 1'b0, 1'b0);

    // Reset in WRITE at index 80
    rand_cycles(2);
    cpu_cycle(TRIG, 8'h05, 1'b1, 1'b0);
    ra = 16'h9ABC;
    run_dma(8'h05, ra, 2 + ((ALIGN_EN == 1 && (tick_count % 2) == 0) ? 1 : 0) + 2 * 8'h80, -1, total);
    tick = 1'b0;
    #2;
    chk("t4_write_addr", {16'h0, busAddress}, {16'h0, DEST});
    chk("t4_write_we", {31'h0, busWriteEnable}, 32'd1);
    chk("t4_write_data", {24'h0, busDataOut}, {24'h0, mem[16'h0580]});
    nReset = 1'b0;
    #1;
    chk("t4_rst_busy", {31'h0, busy}, 32'd0);
    chk("t4_rst_we", {31'h0, busWriteEnable}, 32'd0);
    chk("t4_rst_addr", {16'h0, busAddress}, {16'h0, ra});
    repeat (2) @(posedge clock);
    #1;
    nReset = 1'b1;
    tick_count = 0;
    chk("t4_sb_empty", sb.size(), 32'd0);
    rand_cycles(5);

    // Page FF wraps within FF00..FFFF
    cpu_cycle(TRIG, 8'hFF, 1'b1, 1'b0);
    ra = 16'h7E01;
    run_dma(8'hFF, ra, 0, -1, total);
    chk("t5_low_ticks", low_ticks, total);
    cpu_cycle(ra, 8'h00, 1'b0, 1'b0);
    rand_cycles(4);

    idle(2);
    chk("sb_drained", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
